// File: rtl/fetch.sv
// fetch: instruction-fetch stage plus IF/ID pipeline register.
//
// Owns the architectural fetch PC and issues word fetches to instruction
// memory over a req/ack handshake. Fetched words are registered together
// with PC+4 into the IF/ID register for decode. The stage takes decode's
// branch/jump redirect and the hazard unit's stall.
//
// Ports
//   clock_f       in   1   clock, rising edge
//   reset_n_f     in   1   asynchronous active-low reset
//   stall_f       in   1   freeze PC and IF/ID
//   pc_src_f      in   2   00 seq, 01 branch, 10 jump, 11 treated as seq
//   pc_branch_f   in   32  branch target
//   pc_jump_f     in   32  jump target
//   imem_rdata_f  in   32  instruction word, valid while imem_ack_f=1
//   imem_ack_f    in   1   memory accepts the request and returns data
//   imem_req_f    out  1   fetch request
//   imem_addr_f   out  32  fetch address, word aligned
//   pc_f          out  32  architectural fetch PC
//   inst_d_f      out  32  IF/ID instruction
//   pc_plus4_d_f  out  32  IF/ID PC+4
//   valid_d_f     out  1   IF/ID holds a real instruction
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clock_f,
  input  logic        reset_n_f,
  input  logic        stall_f,
  input  logic [1:0]  pc_src_f,
  input  logic [31:0] pc_branch_f,
  input  logic [31:0] pc_jump_f,
  input  logic [31:0] imem_rdata_f,
  input  logic        imem_ack_f,
  output logic        imem_req_f,
  output logic [31:0] imem_addr_f,
  output logic [31:0] pc_f,
  output logic [31:0] inst_d_f,
  output logic [31:0] pc_plus4_d_f,
  output logic        valid_d_f
);

  // HOLD: a word arrived while stalled and waits in hold_buf.
  // DISCARD: a redirect happened with a request still outstanding; the
  // response to the old address must be swallowed.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] hold_buf, hold_buf_nx;
  logic [31:0] pc_nx, addr_nx, inst_nx, pc4_nx;
  logic        valid_nx, req_nx;
  logic        redirect, ack;
  logic [31:0] target, pc_inc;

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_nx    = state;
    hold_buf_nx = hold_buf;
    pc_nx       = pc_f;
    addr_nx     = imem_addr_f;
    inst_nx     = inst_d_f;
    pc4_nx      = pc_plus4_d_f;
    valid_nx    = valid_d_f;

    redirect = ((pc_src_f == 2'b01) || (pc_src_f == 2'b10)) && !stall_f;
    if (pc_src_f == 2'b01) begin
      target = {pc_branch_f[31:2], 2'b00};
    end else begin
      target = {pc_jump_f[31:2], 2'b00};
    end
    // An ack only counts against a request we are actually making.
    ack    = imem_ack_f && imem_req_f;
    pc_inc = pc_f + 32'd4;

    case (state)
      FETCH: begin
        if (ack) begin
          if (redirect) begin
            pc_nx    = target;
            addr_nx  = target;
            inst_nx  = NOP_INST;
            valid_nx = 1'b0;
          end else if (stall_f) begin
            hold_buf_nx = imem_rdata_f;
            state_nx    = HOLD;
          end else begin
            inst_nx  = imem_rdata_f;
            pc4_nx   = pc_inc;
            valid_nx = 1'b1;
            pc_nx    = pc_inc;
            addr_nx  = pc_inc;
          end
        end else begin
          if (redirect) begin
            pc_nx    = target;
            inst_nx  = NOP_INST;
            valid_nx = 1'b0;
            // Only the very first cycle after reset has no request in flight;
            // then the new target can be requested directly.
            if (imem_req_f) begin
              state_nx = DISCARD;
            end else begin
              addr_nx = target;
            end
          end else if (stall_f) begin
            state_nx = FETCH;
          end else begin
            inst_nx  = NOP_INST;
            valid_nx = 1'b0;
          end
        end
      end
      HOLD: begin
        if (stall_f) begin
          state_nx = HOLD;
        end else if (redirect) begin
          pc_nx    = target;
          addr_nx  = target;
          inst_nx  = NOP_INST;
          valid_nx = 1'b0;
          state_nx = FETCH;
        end else begin
          inst_nx  = hold_buf;
          pc4_nx   = pc_inc;
          valid_nx = 1'b1;
          pc_nx    = pc_inc;
          addr_nx  = pc_inc;
          state_nx = FETCH;
        end
      end
      DISCARD: begin
        if (!stall_f) begin
          inst_nx  = NOP_INST;
          valid_nx = 1'b0;
        end else begin
          valid_nx = valid_d_f;
        end
        if (redirect) begin
          pc_nx = target;
        end else begin
          pc_nx = pc_f;
        end
        // The stale response is dropped; request the (possibly new) PC next.
        if (ack) begin
          addr_nx  = pc_nx;
          state_nx = FETCH;
        end else begin
          state_nx = DISCARD;
        end
      end
      default: begin
        state_nx = FETCH;
      end
    endcase

    req_nx = (state_nx != HOLD);
  end

  // State, PC, request and IF/ID registers.
  always_ff @(posedge clock_f or negedge reset_n_f) begin
    if (!reset_n_f) begin
      state        <= FETCH;
      hold_buf     <= 32'h0000_0000;
      pc_f         <= RESET_PC;
      imem_addr_f  <= RESET_PC;
      imem_req_f   <= 1'b0;
      inst_d_f     <= NOP_INST;
      pc_plus4_d_f <= 32'h0000_0000;
      valid_d_f    <= 1'b0;
    end else begin
      state        <= state_nx;
      hold_buf     <= hold_buf_nx;
      pc_f         <= pc_nx;
      imem_addr_f  <= addr_nx;
      imem_req_f   <= req_nx;
      inst_d_f     <= inst_nx;
      pc_plus4_d_f <= pc4_nx;
      valid_d_f    <= valid_nx;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus a randomized run
// compared against a transaction-level reference model (queue of fetched
// words, stale-response flag).
module tb_fetch;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock_f = 1'b0;
  logic        reset_n_f;
  logic        stall_f;
  logic [1:0]  pc_src_f;
  logic [31:0] pc_branch_f, pc_jump_f, imem_rdata_f;
  logic        imem_ack_f;
  logic        imem_req_f;
  logic [31:0] imem_addr_f, pc_f, inst_d_f, pc_plus4_d_f;
  logic        valid_d_f;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [31:0] m_pc, m_addr, m_inst, m_pc4;
  logic        m_req, m_valid, m_stale;
  logic [31:0] m_q[$];

  fetch dut (
    .clock_f(clock_f), .reset_n_f(reset_n_f), .stall_f(stall_f),
    .pc_src_f(pc_src_f), .pc_branch_f(pc_branch_f), .pc_jump_f(pc_jump_f),
    .imem_rdata_f(imem_rdata_f), .imem_ack_f(imem_ack_f),
    .imem_req_f(imem_req_f), .imem_addr_f(imem_addr_f), .pc_f(pc_f),
    .inst_d_f(inst_d_f), .pc_plus4_d_f(pc_plus4_d_f), .valid_d_f(valid_d_f)
  );

  always #5 clock_f = ~clock_f;

  assign imem_rdata_f = imem_addr_f ^ K;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ K;
  endfunction

  task automatic drive(input logic s, input logic [1:0] src, input logic [31:0] br,
                       input logic [31:0] jp, input logic ack);
    stall_f = s; pc_src_f = src; pc_branch_f = br; pc_jump_f = jp; imem_ack_f = ack;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_inst = NOP; m_pc4 = 32'h0;
    m_req = 1'b0; m_valid = 1'b0; m_stale = 1'b0; m_q.delete();
  endtask

  // one clock edge; the model consumes the same inputs the DUT sampled
  task automatic step();
    logic redir, acc, outstanding;
    logic [31:0] tgt;
    @(posedge clock_f);
    redir = ((pc_src_f == 2'd1) || (pc_src_f == 2'd2)) && !stall_f;
    tgt   = (pc_src_f == 2'd1) ? pc_branch_f : pc_jump_f;
    acc   = m_req && imem_ack_f;
    if (acc) begin
      if (m_stale) m_stale = 1'b0;
      else m_q.push_back(mem(m_addr));
    end
    outstanding = m_req && !acc;
    if (!stall_f) begin
      if (redir) begin
        m_q.delete();
        m_pc = tgt;
        if (outstanding) m_stale = 1'b1;
        m_inst = NOP; m_valid = 1'b0;
      end else if (m_q.size() > 0) begin
        m_inst = m_q.pop_front(); m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        m_inst = NOP; m_valid = 1'b0;
      end
    end
    if (!m_stale) m_addr = m_pc;
    m_req = (m_q.size() == 0);
    #1;
  endtask

  task automatic test_reset();
    reset_n_f = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    repeat (2) @(posedge clock_f);
    #1;
    vectors++;
    if ({imem_req_f, imem_addr_f, pc_f} !== {1'b0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_req_addr_pc: got %b %h %h want 0 00000000 00000000", imem_req_f, imem_addr_f, pc_f);
    end
    vectors++;
    if ({inst_d_f, pc_plus4_d_f, valid_d_f} !== {NOP, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_ifid: got %h %h %b want %h 00000000 0", inst_d_f, pc_plus4_d_f, valid_d_f, NOP);
    end
    reset_n_f = 1'b1;
    model_reset();
    step();
    vectors++;
    if ({imem_req_f, valid_d_f} !== 2'b10) begin
      miscompares++;
      $display("FAIL first_req: got req=%b valid=%b want req=1 valid=0", imem_req_f, valid_d_f);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({inst_d_f, pc_plus4_d_f, valid_d_f} !== {mem(32'(i * 4)), 32'(i * 4 + 4), 1'b1}) begin
        miscompares++;
        $display("FAIL stream%0d: got %h %h %b want %h %h 1", i, inst_d_f, pc_plus4_d_f, valid_d_f,
                 mem(32'(i * 4)), 32'(i * 4 + 4));
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({imem_req_f, pc_f, inst_d_f, pc_plus4_d_f} !== {1'b0, 32'h8, mem(32'h4), 32'h8}) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got req=%b pc=%h inst=%h pc4=%h want 0 8 %h 8", i, imem_req_f, pc_f,
                 inst_d_f, pc_plus4_d_f, mem(32'h4));
      end
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    step();
    vectors++;
    if ({inst_d_f, pc_plus4_d_f, valid_d_f, imem_req_f, imem_addr_f} !== {mem(32'h8), 32'hC, 1'b1, 1'b1, 32'hC}) begin
      miscompares++;
      $display("FAIL stall_release: got %h %h %b %b %h want %h c 1 1 c", inst_d_f, pc_plus4_d_f, valid_d_f,
               imem_req_f, imem_addr_f, mem(32'h8));
    end
    step();
    vectors++;
    if ({inst_d_f, pc_plus4_d_f} !== {mem(32'hC), 32'h10}) begin
      miscompares++;
      $display("FAIL stall_after: got %h %h want %h 10", inst_d_f, pc_plus4_d_f, mem(32'hC));
    end
  endtask

  task automatic test_branch();
    drive(1'b0, 2'd1, 32'h40, 32'h0, 1'b1);
    step();
    vectors++;
    if ({inst_d_f, valid_d_f, imem_addr_f, pc_f} !== {NOP, 1'b0, 32'h40, 32'h40}) begin
      miscompares++;
      $display("FAIL branch_flush: got %h %b %h %h want %h 0 40 40", inst_d_f, valid_d_f, imem_addr_f, pc_f, NOP);
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    step();
    vectors++;
    if ({inst_d_f, valid_d_f, pc_plus4_d_f} !== {mem(32'h40), 1'b1, 32'h44}) begin
      miscompares++;
      $display("FAIL branch_target: got %h %b %h want %h 1 44", inst_d_f, valid_d_f, pc_plus4_d_f, mem(32'h40));
    end
  endtask

  task automatic test_ack_delay();
    drive(1'b0, 2'd2, 32'h0, 32'h20, 1'b1);
    step();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({imem_req_f, imem_addr_f, valid_d_f} !== {1'b1, 32'h20, 1'b0}) begin
        miscompares++;
        $display("FAIL ack_wait%0d: got req=%b addr=%h valid=%b want 1 20 0", i, imem_req_f, imem_addr_f, valid_d_f);
      end
    end
    imem_ack_f = 1'b1;
    step();
    vectors++;
    if ({inst_d_f, valid_d_f} !== {mem(32'h20), 1'b1}) begin
      miscompares++;
      $display("FAIL ack_late: got %h %b want %h 1", inst_d_f, valid_d_f, mem(32'h20));
    end
  endtask

  task automatic test_discard();
    drive(1'b0, 2'd2, 32'h0, 32'h20, 1'b1);
    step();
    drive(1'b0, 2'd2, 32'h0, 32'h100, 1'b0);
    step();
    vectors++;
    if ({imem_addr_f, pc_f, valid_d_f} !== {32'h20, 32'h100, 1'b0}) begin
      miscompares++;
      $display("FAIL discard_enter: got addr=%h pc=%h valid=%b want 20 100 0", imem_addr_f, pc_f, valid_d_f);
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    step();
    vectors++;
    if ({inst_d_f, valid_d_f, imem_addr_f, imem_req_f} !== {NOP, 1'b0, 32'h100, 1'b1}) begin
      miscompares++;
      $display("FAIL discard_drop: got %h %b %h %b want %h 0 100 1", inst_d_f, valid_d_f, imem_addr_f, imem_req_f, NOP);
    end
    step();
    vectors++;
    if ({inst_d_f, valid_d_f, pc_plus4_d_f} !== {mem(32'h100), 1'b1, 32'h104}) begin
      miscompares++;
      $display("FAIL discard_next: got %h %b %h want %h 1 104", inst_d_f, valid_d_f, pc_plus4_d_f, mem(32'h100));
    end
  endtask

  task automatic test_random();
    logic [129:0] got, want;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), $urandom & 32'h0000_0FFC,
            $urandom & 32'h0000_0FFC, ($urandom_range(0, 9) < 7));
      step();
      got  = {imem_req_f, imem_addr_f, pc_f, inst_d_f, pc_plus4_d_f, valid_d_f};
      want = {m_req, m_addr, m_pc, m_inst, m_pc4, m_valid};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'd0, 32'h0, 32'h0, 1'b1);
    // make sure a fetch is pending then stall on its ack
    repeat (3) step();
    vectors++;
    if (imem_req_f !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_before_reset: got req=%b want 0", imem_req_f);
    end
    #2 reset_n_f = 1'b0;
    #1;
    vectors++;
    if ({imem_req_f, imem_addr_f, pc_f, inst_d_f, pc_plus4_d_f, valid_d_f} !==
        {1'b0, 32'h0, 32'h0, NOP, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset: got %b %h %h %h %h %b want all reset values", imem_req_f, imem_addr_f, pc_f,
               inst_d_f, pc_plus4_d_f, valid_d_f);
    end
    #2 reset_n_f = 1'b1;
    model_reset();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    step();
    step();
    vectors++;
    if ({inst_d_f, pc_plus4_d_f, valid_d_f} !== {mem(32'h0), 32'h4, 1'b1}) begin
      miscompares++;
      $display("FAIL restart: got %h %h %b want %h 4 1", inst_d_f, pc_plus4_d_f, valid_d_f, mem(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_ack_delay();
    test_discard();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
